seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digit positions (1..8).
REQ-002 Parameter SETTLE, default 4: consecutive cycles an anode pattern must hold before sampling (1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 seg  input  8  scanned segment bus, active-low; seg[6:0]=g,f,e,d,c,b,a (bit0=a), seg[7]=dp.
REQ-006 pnp  input  8  scanned anode enables, active-low; bit i selects digit i; bits >= DIGITS ignored.
REQ-007 value  output  32  captured hex frame, nibble i = digit i; nibbles >= DIGITS read 0.
REQ-008 dp  output  8  captured decimal points, bit i = digit i, active-high.
REQ-009 frame_valid  output  1  one-cycle pulse when value/dp update.
REQ-010 err  output  1  sticky frame error flag, cleared on next frame_valid or rst.

Function
REQ-011 seg and pnp SHALL pass through a 2-flop synchronizer; all further timing is counted from synchronized signals.
REQ-012 FSM states: IDLE (no anode active), SETTLE (one anode active, counting), HELD (digit sampled, waiting for anode change).
REQ-013 IDLE -> SETTLE when exactly one anode bit is low; settle counter loads 1.
REQ-014 In SETTLE, counter increments while pnp and seg are unchanged; any change to pnp or seg restarts counting (new anode -> SETTLE count 1, no anode -> IDLE).
REQ-015 SETTLE -> HELD when counter reaches SETTLE; the digit is sampled on that cycle.
REQ-016 HELD -> SETTLE on a different single anode, -> IDLE on no anode; unchanged pattern stays in HELD without resampling.
REQ-017 Two or more anode bits low: no sample, FSM to IDLE, err set.
REQ-018 Sampling SHALL decode seg[6:0] via fixed active-low table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E (hex, gfedcba).
REQ-019 Valid pattern: nibble stored in shadow buffer slot i, capture mask bit i set; dp slot i = ~seg[7].
REQ-020 Invalid pattern: slot not written, mask bit unchanged, err set.
REQ-021 Re-capture of an already-masked digit within a frame SHALL overwrite its slot.
REQ-022 When mask has all DIGITS bits set, on the next cycle: value/dp load from shadow, frame_valid pulses 1 cycle, mask clears.
REQ-023 A sample taken on the frame_valid cycle SHALL count toward the following frame.
REQ-024 Latency: sync (2) + SETTLE cycles from anode edge to sample; frame_valid 1 cycle after final mask bit.

Reset
REQ-025 On rst: FSM IDLE, counter 0, mask 0, shadow 0, synchronizers 1 (inactive), value 0, dp 0, frame_valid 0, err 0.
REQ-026 rst mid-frame SHALL discard the partial frame; no frame_valid is produced for it.

Configuration
REQ-027 Macro SEG_CAPTURE_DP_EN: defined -> dp captured per REQ-019; undefined -> seg[7] ignored, no dp storage, dp output constant 0.

Structure
REQ-028 Shared package seg_pkg: FSM state enum, 16-entry segment pattern table constant, SEG_WIDTH=8, MAX_DIGITS=8.
REQ-029 Sub-module seg_to_hex (combinational): 7-bit pattern in -> 4-bit nibble + valid out, using the package table.

Verification
REQ-030 Scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 10 cycles -> one frame_valid, value=32'h87654321, err=0.
REQ-031 Digit held only SETTLE-1 cycles then anode moves -> digit not captured, no frame_valid until it is rescanned.
REQ-032 Digit 3 driven with seg=7F (blank) -> err=1, no frame_valid; next clean full scan -> frame_valid, err clears.
REQ-033 pnp=8'hFC (two anodes) for 10 cycles -> err=1, mask unchanged.
REQ-034 rst asserted after 5 of 8 digits captured, then full scan of all 'A' -> value=32'hAAAAAAAA, exactly one frame_valid.
REQ-035 With SEG_CAPTURE_DP_EN, dp lit on digits 0 and 7 -> dp=8'h81; without macro -> dp=8'h00.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the segment-scan capture block.
package seg_pkg;

  localparam int SEG_WIDTH  = 8;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } seg_state_e;

  // Active-low gfedcba patterns; entry i is the pattern shown for hex digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] count_ones(input logic [MAX_DIGITS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational 7-segment (active-low gfedcba) to hex nibble decoder.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  // Table entries are distinct, so OR-ing the matching index is exact.
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nibble = nibble | ({4{pattern == SEG_TABLE[i]}} & 4'(i));
      valid  = valid | (pattern == SEG_TABLE[i]);
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 7-segment scan into a hex frame with per-digit settling.
// Optional macro SEG_CAPTURE_DP_EN enables decimal-point capture on dp.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [7:0]  pnp,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic        err
);

  localparam logic [MAX_DIGITS-1:0] DIGIT_MASK   = 8'((9'd1 << DIGITS) - 9'd1);
  localparam logic [7:0]            SETTLE_CNT   = 8'(SETTLE);
  localparam seg_state_e            START_STATE  = (SETTLE == 1) ? ST_HELD : ST_SETTLE;
  localparam logic                  START_SAMPLE = 1'(SETTLE == 1);
`ifdef SEG_CAPTURE_DP_EN
  localparam logic [SEG_WIDTH-1:0]  SEG_CMP_MASK = 8'hFF;
`else
  localparam logic [SEG_WIDTH-1:0]  SEG_CMP_MASK = 8'h7F;
`endif

  logic [SEG_WIDTH-1:0]  seg_meta_r, seg_sync_r, seg_prev_r;
  logic [MAX_DIGITS-1:0] pnp_meta_r, pnp_sync_r, act_prev_r;
  seg_state_e            state_r, state_s;
  logic [7:0]            cnt_r, cnt_s;
  logic [MAX_DIGITS-1:0] mask_r, mask_s;
  logic [31:0]           shadow_r, value_r;
  logic                  frame_valid_r, err_r, err_s;
  logic [MAX_DIGITS-1:0] act_s;
  logic [3:0]            act_cnt_s;
  logic [2:0]            idx_s;
  logic                  changed_s, sample_s, multi_s, frame_done_s;
  logic                  sample_ok_s, sample_bad_s;
  logic [3:0]            hex_s;
  logic                  hex_valid_s;

  seg_to_hex u_seg_to_hex (
    .pattern (seg_sync_r[6:0]),
    .nibble  (hex_s),
    .valid   (hex_valid_s)
  );

  // Synchronizers idle high (inactive); prev copies feed change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta_r <= 8'hFF;
      seg_sync_r <= 8'hFF;
      pnp_meta_r <= 8'hFF;
      pnp_sync_r <= 8'hFF;
      seg_prev_r <= 8'hFF;
      act_prev_r <= 8'h00;
    end else begin
      seg_meta_r <= seg;
      seg_sync_r <= seg_meta_r;
      pnp_meta_r <= pnp;
      pnp_sync_r <= pnp_meta_r;
      seg_prev_r <= seg_sync_r;
      act_prev_r <= act_s;
    end
  end

  // Active anode decode and change detection on the synchronized bus.
  always_comb begin
    act_s     = ~pnp_sync_r & DIGIT_MASK;
    act_cnt_s = count_ones(act_s);
    changed_s = (act_s != act_prev_r) ||
                ((seg_sync_r & SEG_CMP_MASK) != (seg_prev_r & SEG_CMP_MASK));
    idx_s     = 3'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      idx_s = idx_s | ({3{act_s[i]}} & 3'(i));
    end
  end

  // Next-state logic; a fresh single-anode pattern always restarts at count 1.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    sample_s = 1'b0;
    multi_s  = 1'b0;
    if (act_cnt_s > 4'd1) begin
      multi_s = 1'b1;
      state_s = ST_IDLE;
      cnt_s   = 8'd0;
    end else if (act_cnt_s == 4'd0) begin
      state_s = ST_IDLE;
      cnt_s   = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s  = START_STATE;
          cnt_s    = 8'd1;
          sample_s = START_SAMPLE;
        end
        ST_SETTLE: begin
          if (changed_s) begin
            state_s  = START_STATE;
            cnt_s    = 8'd1;
            sample_s = START_SAMPLE;
          end else if (cnt_r + 8'd1 == SETTLE_CNT) begin
            state_s  = ST_HELD;
            cnt_s    = cnt_r + 8'd1;
            sample_s = 1'b1;
          end else begin
            state_s  = ST_SETTLE;
            cnt_s    = cnt_r + 8'd1;
          end
        end
        ST_HELD: begin
          if (changed_s) begin
            state_s  = START_STATE;
            cnt_s    = 8'd1;
            sample_s = START_SAMPLE;
          end else begin
            state_s  = ST_HELD;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end
      endcase
    end
  end

  // FSM state and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // A sample on the frame-complete cycle lands in the freshly cleared mask.
  always_comb begin
    frame_done_s = (mask_r == DIGIT_MASK);
    sample_ok_s  = sample_s & hex_valid_s;
    sample_bad_s = sample_s & ~hex_valid_s;
    mask_s       = (frame_done_s ? 8'h00 : mask_r) | (sample_ok_s ? act_s : 8'h00);
    if (multi_s || sample_bad_s) begin
      err_s = 1'b1;
    end else if (frame_done_s) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Shadow buffer, capture mask, frame publish and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r        <= 8'h00;
      shadow_r      <= 32'h0000_0000;
      value_r       <= 32'h0000_0000;
      frame_valid_r <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      mask_r        <= mask_s;
      err_r         <= err_s;
      frame_valid_r <= frame_done_s;
      if (frame_done_s) begin
        value_r <= shadow_r;
      end
      if (sample_ok_s) begin
        shadow_r[{idx_s, 2'b00} +: 4] <= hex_s;
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic [MAX_DIGITS-1:0] dp_shadow_r, dp_r;

  // Decimal points follow the same slot/publish rules as the nibbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_shadow_r <= 8'h00;
      dp_r        <= 8'h00;
    end else begin
      if (sample_ok_s) begin
        dp_shadow_r[idx_s] <= ~seg_sync_r[7];
      end
      if (frame_done_s) begin
        dp_r <= dp_shadow_r;
      end
    end
  end

  assign dp = dp_r;
`else
  assign dp = 8'h00;
`endif

  assign value       = value_r;
  assign frame_valid = frame_valid_r;
  assign err         = err_r;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed tables plus random scans vs a reference model.
module tb_seg_scan_capture;

  localparam int DIGITS = 8;
  localparam int SETTLE = 4;
`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] DP_KEEP  = 8'hFF;
  localparam logic [7:0] CMP_KEEP = 8'hFF;
`else
  localparam logic [7:0] DP_KEEP  = 8'h00;
  localparam logic [7:0] CMP_KEEP = 8'h7F;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg, pnp;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        frame_valid, err;

  always #5 clk = ~clk;

  seg_scan_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .seg(seg), .pnp(pnp),
    .value(value), .dp(dp), .frame_valid(frame_valid), .err(err)
  );

  typedef struct {
    logic [31:0] frame;
    logic [7:0]  dpb;
    logic [31:0] exp_value;
    logic [7:0]  exp_dp;
  } vec_t;

  logic [6:0] pat_tab [16];
  vec_t       vecs [4];
  int checks = 0;
  int failures = 0;
  int fv_seen = 0;

  // Reference model: synchronizer image, run length of the stable pattern, frame buffer.
  logic [7:0]  m_pnp_meta, m_pnp_sync, m_seg_meta, m_seg_sync, m_prev_act, m_prev_seg;
  int          m_run;
  logic [3:0]  m_nib [8];
  logic [7:0]  m_dpsh, m_mask, m_dp;
  logic [31:0] m_value;
  logic        m_fv, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [6:0] p, output logic [3:0] n);
    n = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat_tab[i] == p) begin
        n = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_pnp_meta = 8'hFF; m_pnp_sync = 8'hFF;
    m_seg_meta = 8'hFF; m_seg_sync = 8'hFF;
    m_prev_act = 8'h00; m_prev_seg = 8'hFF & CMP_KEEP;
    m_run = 0;
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_dpsh = 8'h00; m_mask = 8'h00; m_dp = 8'h00;
    m_value = 32'h0; m_fv = 1'b0; m_err = 1'b0;
  endfunction

  // A digit is sampled on the cycle its single-anode pattern has been stable SETTLE cycles.
  function automatic void model_step(input logic [7:0] pin, input logic [7:0] sin);
    logic [7:0] act, sg;
    logic [3:0] nib;
    int d;
    act = ~m_pnp_sync;
    sg  = m_seg_sync & CMP_KEEP;
    if (act == m_prev_act && sg == m_prev_seg) begin
      if (m_run < SETTLE + 1) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev_act = act;
    m_prev_seg = sg;
    m_fv = (m_mask == 8'hFF);
    if (m_fv) begin
      for (int i = 0; i < 8; i++) m_value[i*4 +: 4] = m_nib[i];
      m_dp   = m_dpsh & DP_KEEP;
      m_mask = 8'h00;
      m_err  = 1'b0;
    end
    if ($countones(act) > 1) begin
      m_err = 1'b1;
    end else if ($countones(act) == 1 && m_run == SETTLE) begin
      d = 0;
      for (int i = 0; i < 8; i++) if (act[i]) d = i;
      if (lookup(m_seg_sync[6:0], nib)) begin
        m_nib[d]  = nib;
        m_mask[d] = 1'b1;
        m_dpsh[d] = ~m_seg_sync[7];
      end else begin
        m_err = 1'b1;
      end
    end
    m_pnp_sync = m_pnp_meta; m_seg_sync = m_seg_meta;
    m_pnp_meta = pin;        m_seg_meta = sin;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(pnp, seg);
    #1;
    check("value", value, m_value);
    check("dp", {24'h0, dp}, {24'h0, m_dp});
    check("frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
    check("err", {31'h0, err}, {31'h0, m_err});
    if (frame_valid) fv_seen++;
  endtask

  task automatic hold(input logic [7:0] p, input logic [7:0] s, input int n);
    pnp = p;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic scan_digit(input int d, input logic [3:0] nib, input logic dp_on, input int n);
    hold(~(8'h01 << d), {~dp_on, pat_tab[nib]}, n);
  endtask

  task automatic scan_frame(input logic [31:0] frame, input logic [7:0] dpb);
    for (int i = 0; i < 8; i++) scan_digit(i, frame[i*4 +: 4], dpb[i], 10);
    hold(8'hFF, 8'hFF, 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    fv_seen = 0;
  endtask

  initial begin
    pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{32'h87654321, 8'h00, 32'h87654321, 8'h00};
    vecs[1] = '{32'hFEDCBA90, 8'h81, 32'hFEDCBA90, 8'h81 & DP_KEEP};
    vecs[2] = '{32'h00000000, 8'hFF, 32'h00000000, 8'hFF & DP_KEEP};
    vecs[3] = '{32'h13579BDF, 8'h5A, 32'h13579BDF, 8'h5A & DP_KEEP};
    rst = 1'b1;
    pnp = 8'hFF;
    seg = 8'hFF;
    do_reset();
    check("rst_value", value, 32'h0);
    check("rst_dp", {24'h0, dp}, 32'h0);
    check("rst_fv", {31'h0, frame_valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);

    // Table of clean full-frame scans.
    for (int v = 0; v < 4; v++) begin
      fv_seen = 0;
      scan_frame(vecs[v].frame, vecs[v].dpb);
      check("tab_fv_count", 32'(fv_seen), 32'd1);
      check("tab_value", value, vecs[v].exp_value);
      check("tab_dp", {24'h0, dp}, {24'h0, vecs[v].exp_dp});
      check("tab_err", {31'h0, err}, 32'h0);
    end

    // Digit 5 held only SETTLE-1 cycles is skipped until rescanned.
    do_reset();
    for (int i = 0; i < 8; i++) scan_digit(i, 4'(i + 1), 1'b0, (i == 5) ? SETTLE - 1 : 10);
    hold(8'hFF, 8'hFF, 6);
    check("short_no_fv", 32'(fv_seen), 32'd0);
    scan_digit(5, 4'h6, 1'b0, 10);
    hold(8'hFF, 8'hFF, 6);
    check("short_fv", 32'(fv_seen), 32'd1);
    check("short_value", value, 32'h87654321);

    // Blank digit 3 flags an error; the next clean scan publishes and clears it.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) hold(~(8'h01 << i), 8'h7F, 10);
      else scan_digit(i, 4'(i + 1), 1'b0, 10);
    end
    hold(8'hFF, 8'hFF, 6);
    check("blank_err", {31'h0, err}, 32'h1);
    check("blank_no_fv", 32'(fv_seen), 32'd0);
    scan_frame(32'h87654321, 8'h00);
    check("blank_fv", 32'(fv_seen), 32'd1);
    check("blank_value", value, 32'h87654321);
    check("blank_err_clr", {31'h0, err}, 32'h0);

    // Two anodes at once keep the partial mask and set err.
    do_reset();
    for (int i = 0; i < 7; i++) scan_digit(i, 4'(i + 1), 1'b0, 10);
    hold(8'hFC, 8'hF9, 10);
    hold(8'hFF, 8'hFF, 4);
    check("multi_err", {31'h0, err}, 32'h1);
    check("multi_no_fv", 32'(fv_seen), 32'd0);
    scan_digit(7, 4'h8, 1'b0, 10);
    hold(8'hFF, 8'hFF, 6);
    check("multi_fv", 32'(fv_seen), 32'd1);
    check("multi_value", value, 32'h87654321);
    check("multi_err_clr", {31'h0, err}, 32'h0);

    // Re-capture of digit 0 within a frame overwrites its slot.
    do_reset();
    scan_digit(0, 4'h1, 1'b0, 10);
    scan_digit(1, 4'h2, 1'b0, 10);
    scan_digit(0, 4'hC, 1'b0, 10);
    for (int i = 2; i < 8; i++) scan_digit(i, 4'(i + 1), 1'b0, 10);
    hold(8'hFF, 8'hFF, 6);
    check("recap_fv", 32'(fv_seen), 32'd1);
    check("recap_value", value, 32'h8765432C);

    // Reset after a partial frame discards it.
    do_reset();
    for (int i = 0; i < 5; i++) scan_digit(i, 4'(i + 1), 1'b0, 10);
    hold(8'hFF, 8'hFF, 4);
    do_reset();
    scan_frame(32'hAAAAAAAA, 8'h00);
    check("rstmid_fv", 32'(fv_seen), 32'd1);
    check("rstmid_value", value, 32'hAAAAAAAA);

    // Random scanning against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int r, a, b;
      logic [7:0] p, s;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 7);
      b = (a + 1 + $urandom_range(0, 6)) % 8;
      if (r < 7) p = ~(8'h01 << a);
      else if (r == 7) p = 8'hFF;
      else p = ~((8'h01 << a) | (8'h01 << b));
      if ($urandom_range(0, 5) == 0) s = 8'($urandom);
      else s = {1'($urandom), pat_tab[$urandom_range(0, 15)]};
      hold(p, s, $urandom_range(1, 8));
    end
    hold(8'hFF, 8'hFF, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
